// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: per-stage stall, bubble and flush enables, deferred flushes, stall watchdog.
// Optional saturating perf counters are built when STALL_PERF_EN is defined.
module stall_ctrl #(
    parameter int                    NUM_STAGES    = 5,
    parameter logic [NUM_STAGES-1:0] PC_STALL_MASK = NUM_STAGES'(2),
    parameter int                    WDOG_W        = 8,
    parameter int                    WDOG_LIMIT    = 200,
    parameter int                    PERF_W        = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_STAGES-1:0] stall_req_i,
    input  logic [NUM_STAGES-1:0] flush_req_i,
    input  logic                  wdog_clr_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] bubble_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  stall_active_o,
    output logic                  wdog_timeout_o,
    output logic [PERF_W-1:0]     perf_stall_o,
    output logic [PERF_W-1:0]     perf_flush_o
);

    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_LIMIT);

    logic [NUM_STAGES-1:0] pend_q;
    logic [NUM_STAGES-1:0] pend_d;
    logic [NUM_STAGES-1:0] issue;
    logic [NUM_STAGES-1:0] kill;
    logic [NUM_STAGES-1:0] req_eff;
    logic [NUM_STAGES-1:0] stall_c;
    logic [NUM_STAGES-1:0] bubble_c;
    logic [NUM_STAGES-1:0] flush_c;
    logic                  active_c;
    logic [WDOG_W-1:0]     wdog_q;
    logic [WDOG_W-1:0]     wdog_d;
    logic                  timeout_q;

    // Walk from WB toward IF: an issuing flush kills every younger stage's stall request.
    always_comb begin : comb_eval
        logic kill_acc;
        logic req_acc;
        kill_acc = 1'b0;
        req_acc  = 1'b0;
        issue    = '0;
        kill     = '0;
        req_eff  = '0;
        stall_c  = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            kill[k]    = kill_acc;
            req_eff[k] = stall_req_i[k] & ~kill_acc;
            req_acc    = req_acc | req_eff[k];
            if (k == 0) begin
                stall_c[0] = |(req_eff & PC_STALL_MASK);
            end else begin
                stall_c[k] = req_acc;
            end
            issue[k] = (flush_req_i[k] | pend_q[k]) & ~stall_c[k];
            kill_acc = kill_acc | issue[k];
        end
        flush_c = kill | issue;
    end

    always_comb begin
        bubble_c = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            bubble_c[k] = stall_c[k-1] & ~stall_c[k] & ~flush_c[k];
        end
    end

    assign active_c       = |stall_c;
    assign stall_o        = rst_n_i ? stall_c  : '0;
    assign bubble_o       = rst_n_i ? bubble_c : '0;
    assign flush_o        = rst_n_i ? flush_c  : '0;
    assign stall_active_o = |stall_o;
    assign wdog_timeout_o = timeout_q;

    // A blocked flush is remembered until it issues or an older flush makes it moot.
    assign pend_d = (pend_q | (flush_req_i & stall_c)) & ~issue & ~kill;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        wdog_d = '0;
        if (active_c) begin
            wdog_d = (wdog_q == WDOG_LIM) ? wdog_q : wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (wdog_clr_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            if (active_c && (wdog_d == WDOG_LIM)) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef STALL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_flush_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (active_c && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
            if ((|issue) && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 1'b1;
            end
        end
    end

    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`else
    assign perf_stall_o = '0;
    assign perf_flush_o = '0;
`endif

endmodule
